// File: rtl/writeback_commit_rob_pkg.sv
// Shared definitions for the writeback/commit reorder buffer.
// Contents:
//   rob_entry_t - payload stored per ROB slot (pc, waddr, preg, wdata, wen)
//   f_younger   - age compare of two sequence numbers relative to the ROB head
package writeback_commit_rob_pkg;

  // Widest sequence number the age helper handles; callers zero-extend.
  localparam int lp_seq_max_bits  = 8;
  // Physical register field width held in each entry. The top's
  // p_phys_addr_bits must not exceed this value.
  localparam int lp_rob_preg_bits = 6;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [4:0]                  waddr;
    logic [lp_rob_preg_bits-1:0] preg;
    logic [31:0]                 wdata;
    logic                        wen;
  } rob_entry_t;

  // True when s is strictly younger than ref_s. Age is the distance from the
  // head, taken modulo the ROB depth; i_mask is depth-1.
  function automatic logic f_younger(
    input logic [lp_seq_max_bits-1:0] i_s,
    input logic [lp_seq_max_bits-1:0] i_ref_s,
    input logic [lp_seq_max_bits-1:0] i_head,
    input logic [lp_seq_max_bits-1:0] i_mask
  );
    logic [lp_seq_max_bits-1:0] w_age_s;
    logic [lp_seq_max_bits-1:0] w_age_ref;
    w_age_s   = (i_s - i_head) & i_mask;
    w_age_ref = (i_ref_s - i_head) & i_mask;
    return (w_age_s > w_age_ref);
  endfunction

endpackage

// File: rtl/writeback_commit_rob_if.sv
// Bundle of execute-pipe, completion, commit and squash signals.
// master: execute pipes / environment (drives ex_*, squash_*).
// slave : writeback_commit_rob (drives ex_rdy, complete_*, commit_*).
interface writeback_commit_rob_if #(
  parameter int p_num_pipes      = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  parameter int p_commit_width   = 2
);

  // Execute pipes -> writeback
  logic [p_num_pipes-1:0]                       ex_val;
  logic [p_num_pipes-1:0]                       ex_rdy;
  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]   ex_seq_num;
  logic [p_num_pipes-1:0][31:0]                 ex_pc;
  logic [p_num_pipes-1:0][4:0]                  ex_waddr;
  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0] ex_preg;
  logic [p_num_pipes-1:0][31:0]                 ex_wdata;
  logic [p_num_pipes-1:0]                       ex_wen;

  // Completion notification
  logic                        complete_val;
  logic [p_seq_num_bits-1:0]   complete_seq_num;
  logic [4:0]                  complete_waddr;
  logic [p_phys_addr_bits-1:0] complete_preg;
  logic [31:0]                 complete_wdata;
  logic                        complete_wen;

  // In-order commit slots
  logic [p_commit_width-1:0]                       commit_val;
  logic [p_commit_width-1:0][p_seq_num_bits-1:0]   commit_seq_num;
  logic [p_commit_width-1:0][31:0]                 commit_pc;
  logic [p_commit_width-1:0][4:0]                  commit_waddr;
  logic [p_commit_width-1:0][p_phys_addr_bits-1:0] commit_preg;
  logic [p_commit_width-1:0][31:0]                 commit_wdata;
  logic [p_commit_width-1:0]                       commit_wen;

  // Squash request
  logic                      squash_val;
  logic [p_seq_num_bits-1:0] squash_seq_num;

  modport master (
    output ex_val, ex_seq_num, ex_pc, ex_waddr, ex_preg, ex_wdata, ex_wen,
    output squash_val, squash_seq_num,
    input  ex_rdy,
    input  complete_val, complete_seq_num, complete_waddr, complete_preg,
    input  complete_wdata, complete_wen,
    input  commit_val, commit_seq_num, commit_pc, commit_waddr, commit_preg,
    input  commit_wdata, commit_wen
  );

  modport slave (
    input  ex_val, ex_seq_num, ex_pc, ex_waddr, ex_preg, ex_wdata, ex_wen,
    input  squash_val, squash_seq_num,
    output ex_rdy,
    output complete_val, complete_seq_num, complete_waddr, complete_preg,
    output complete_wdata, complete_wen,
    output commit_val, commit_seq_num, commit_pc, commit_waddr, commit_preg,
    output commit_wdata, commit_wen
  );

endinterface

// File: rtl/writeback_commit_rob_chk.sv
// Protocol checker for writeback_commit_rob.
// Ports:
//   clk, rst       - clock and synchronous reset (checks disabled in reset)
//   i_accept       - a transfer is being written into the ROB this cycle
//   i_target_valid - the ROB slot addressed by that transfer is already valid
module writeback_commit_rob_chk (
  input logic clk,
  input logic rst,
  input logic i_accept,
  input logic i_target_valid
);

  // A live slot being overwritten means upstream reused an in-flight seq_num.
  a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
    !(i_accept && i_target_valid))
    else $error("writeback_commit_rob: transfer into an already-valid ROB entry");

endmodule

// File: rtl/writeback_commit_rob_rr_arbiter.sv
// Round-robin arbiter, one grant per cycle.
// Ports:
//   clk, rst - clock, synchronous active-high reset (pointer -> 0)
//   i_en     - grant enable; no grant and no pointer move while low
//   i_req    - request vector
//   o_gnt    - one-hot grant (0 when nothing requests)
//   o_idx    - index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter  int p_num_req = 4,
  localparam int lp_w      = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [p_num_req-1:0] i_req,
  output logic [p_num_req-1:0] o_gnt,
  output logic [lp_w-1:0]      o_idx
);

  logic [lp_w-1:0] r_ptr;
  logic [lp_w:0]   w_sum;
  logic            w_found;

  // Scan requesters starting at the priority pointer, first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int i = 0; i < p_num_req; i++) begin
      // (ptr + i) mod p_num_req without a divider; works for any count.
      w_sum = {1'b0, r_ptr} + (lp_w+1)'(i);
      if (w_sum >= (lp_w+1)'(p_num_req)) begin
        w_sum = w_sum - (lp_w+1)'(p_num_req);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && i_en && i_req[w_sum[lp_w-1:0]]) begin
        o_gnt[w_sum[lp_w-1:0]] = 1'b1;
        o_idx                  = w_sum[lp_w-1:0];
        w_found                = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Priority moves just past the winner after every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_idx == lp_w'(p_num_req - 1)) ? '0 : o_idx + lp_w'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/writeback_commit_rob.sv
// Writeback arbitration plus reorder buffer with in-order multi-slot commit.
// Ports:
//   clk - sole clock, rising edge
//   rst - synchronous active-high reset; clears ROB, head and arbiter pointer
//   bus - writeback_commit_rob_if.slave:
//         ex_*       per-pipe valid/ready and payload (round-robin granted)
//         complete_* combinational echo of the accepted transfer
//         commit_*   up to p_commit_width in-order commits from registered state
//         squash_*   clear every entry younger than squash_seq_num
module writeback_commit_rob
  import writeback_commit_rob_pkg::*;
#(
  parameter int p_num_pipes      = 4,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  parameter int p_commit_width   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  writeback_commit_rob_if.slave  bus
);

  localparam int lp_depth = 1 << p_seq_num_bits;
  localparam int lp_sel_w = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;
  localparam logic [lp_seq_max_bits-1:0] lp_seq_mask = lp_seq_max_bits'(lp_depth - 1);

  logic                      r_rst_q;
  logic                      w_en;
  logic [p_num_pipes-1:0]    w_gnt;
  logic [lp_sel_w-1:0]       w_sel;
  logic                      w_xfer;
  logic                      w_discard;
  logic                      w_accept;
  logic [p_seq_num_bits-1:0] w_seq;
  rob_entry_t                w_entry;

  logic [lp_depth-1:0]       r_valid;
  logic [lp_depth-1:0]       w_valid_nxt;
  rob_entry_t                r_rob [lp_depth];
  logic [p_seq_num_bits-1:0] r_head;
  logic [p_seq_num_bits-1:0] w_cnt;
  logic                      w_run;
  logic [p_commit_width-1:0] w_cval;
  logic [p_seq_num_bits-1:0] w_slot [p_commit_width];

  // Outputs stay quiet while rst is high and for one cycle after it drops.
  assign w_en = !rst && !r_rst_q;

  rr_arbiter #(
    .p_num_req (p_num_pipes)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_req (bus.ex_val),
    .o_gnt (w_gnt),
    .o_idx (w_sel)
  );

  assign bus.ex_rdy = w_gnt;

  // Select the granted pipe; a squashed-younger transfer is taken but dropped.
  always_comb begin
    w_xfer        = |w_gnt;
    w_seq         = bus.ex_seq_num[w_sel];
    w_entry.pc    = bus.ex_pc[w_sel];
    w_entry.waddr = bus.ex_waddr[w_sel];
    w_entry.preg  = lp_rob_preg_bits'(bus.ex_preg[w_sel]);
    w_entry.wdata = bus.ex_wdata[w_sel];
    w_entry.wen   = bus.ex_wen[w_sel];
    w_discard     = w_xfer && bus.squash_val &&
                    f_younger(lp_seq_max_bits'(w_seq),
                              lp_seq_max_bits'(bus.squash_seq_num),
                              lp_seq_max_bits'(r_head), lp_seq_mask);
    w_accept      = w_xfer && !w_discard;
  end

  assign bus.complete_val     = w_accept;
  assign bus.complete_seq_num = w_seq;
  assign bus.complete_waddr   = bus.ex_waddr[w_sel];
  assign bus.complete_preg    = bus.ex_preg[w_sel];
  assign bus.complete_wdata   = bus.ex_wdata[w_sel];
  assign bus.complete_wen     = bus.ex_wen[w_sel];

  // Commit slot k needs head..head+k all valid; the running AND gives no gaps.
  always_comb begin
    w_cnt  = '0;
    w_cval = '0;
    w_run  = w_en;
    for (int k = 0; k < p_commit_width; k++) begin
      w_slot[k] = r_head + p_seq_num_bits'(k);
      w_run     = w_run & r_valid[w_slot[k]];
      w_cval[k] = w_run;
      w_cnt     = w_cnt + p_seq_num_bits'(w_cval[k]);
    end
  end

  // Drive commit slots straight from registered ROB contents.
  always_comb begin
    bus.commit_val = w_cval;
    for (int k = 0; k < p_commit_width; k++) begin
      bus.commit_seq_num[k] = w_slot[k];
      bus.commit_pc[k]      = r_rob[w_slot[k]].pc;
      bus.commit_waddr[k]   = r_rob[w_slot[k]].waddr;
      bus.commit_preg[k]    = p_phys_addr_bits'(r_rob[w_slot[k]].preg);
      bus.commit_wdata[k]   = r_rob[w_slot[k]].wdata;
      bus.commit_wen[k]     = r_rob[w_slot[k]].wen;
    end
  end

  // Next valid bits: retire commits, clear squashed-younger slots, add the write.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int k = 0; k < p_commit_width; k++) begin
      w_valid_nxt[w_slot[k]] = w_valid_nxt[w_slot[k]] & ~w_cval[k];
    end
    for (int s = 0; s < lp_depth; s++) begin
      w_valid_nxt[s] = w_valid_nxt[s] &
                       ~(bus.squash_val &
                         f_younger(lp_seq_max_bits'(s),
                                   lp_seq_max_bits'(bus.squash_seq_num),
                                   lp_seq_max_bits'(r_head), lp_seq_mask));
    end
    w_valid_nxt[w_seq] = w_valid_nxt[w_seq] | w_accept;
  end

  // Valid bits, head pointer and the reset-trailing flag.
  always_ff @(posedge clk) begin
    r_rst_q <= rst;
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_head  <= r_head + w_cnt;
    end
  end

  // Entry payload needs no reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rob[w_seq] <= w_entry;
    end
  end

`ifndef SYNTHESIS
  writeback_commit_rob_chk u_chk (
    .clk            (clk),
    .rst            (rst),
    .i_accept       (w_accept),
    .i_target_valid (r_valid[w_seq])
  );

  // One-line state summary for debug traces.
  function automatic string f_linetrace();
    return $sformatf("head=%0d valid=%h gnt=%b cval=%b", r_head, r_valid, w_gnt, w_cval);
  endfunction
`endif

endmodule

// File: tb/tb_writeback_commit_rob.sv
// Self-checking bench for writeback_commit_rob: directed scenarios plus a long
// randomized run, all checked cycle by cycle against a sequence-number model.
module tb_writeback_commit_rob;
  localparam int N  = 4;
  localparam int SB = 5;
  localparam int PB = 6;
  localparam int W  = 2;
  localparam int D  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_commit_rob_if #(.p_num_pipes(N), .p_seq_num_bits(SB),
                            .p_phys_addr_bits(PB), .p_commit_width(W)) bus ();

  writeback_commit_rob #(.p_num_pipes(N), .p_seq_num_bits(SB),
                         .p_phys_addr_bits(PB), .p_commit_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: sequence numbers are tracked as unbounded integers ("abs"); the
  // hardware seq_num is abs mod D, and "younger" is simply a larger abs.
  bit            m_valid [D];
  int            m_abs   [D];
  logic [31:0]   m_pc    [D];
  logic [31:0]   m_wd    [D];
  logic [4:0]    m_wa    [D];
  logic [PB-1:0] m_pr    [D];
  logic          m_we    [D];
  int            m_head;
  int            m_ptr;
  bit            m_rst_prev;

  bit            p_val [N];
  int            p_abs [N];
  logic [31:0]   p_pc  [N];
  logic [31:0]   p_wd  [N];
  logic [4:0]    p_wa  [N];
  logic [PB-1:0] p_pr  [N];
  logic          p_we  [N];
  int            tail;
  bit            sq_val;
  int            sq_abs;

  function automatic int model_ncommit();
    int n = 0;
    if (rst || m_rst_prev) return 0;
    while (n < W && m_valid[(m_head + n) % D]) n++;
    return n;
  endfunction

  task automatic issue(input int p, input int abs);
    p_val[p] = 1'b1;
    p_abs[p] = abs;
    p_pc[p]  = $urandom;
    p_wd[p]  = $urandom;
    p_wa[p]  = 5'($urandom);
    p_pr[p]  = PB'($urandom);
    p_we[p]  = 1'($urandom);
  endtask

  task automatic model_reset();
    for (int s = 0; s < D; s++) m_valid[s] = 1'b0;
    for (int p = 0; p < N; p++) p_val[p] = 1'b0;
    m_head = 0;
    m_ptr  = 0;
    tail   = 0;
    sq_val = 1'b0;
    sq_abs = 0;
  endtask

  // One clock: drive, check combinational outputs at negedge, advance model.
  task automatic cycle();
    int g;
    int n;
    int idx;
    bit acc;
    for (int p = 0; p < N; p++) begin
      bus.ex_val[p]     = p_val[p];
      bus.ex_seq_num[p] = SB'(p_abs[p] % D);
      bus.ex_pc[p]      = p_pc[p];
      bus.ex_waddr[p]   = p_wa[p];
      bus.ex_preg[p]    = p_pr[p];
      bus.ex_wdata[p]   = p_wd[p];
      bus.ex_wen[p]     = p_we[p];
    end
    bus.squash_val     = sq_val;
    bus.squash_seq_num = SB'(sq_abs % D);
    @(negedge clk);
    g = -1;
    if (!rst && !m_rst_prev) begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && p_val[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      end
    end
    check_eq("ex_rdy", bus.ex_rdy, (g >= 0) ? (64'd1 << g) : 64'd0);
    acc = (g >= 0) && !(sq_val && p_abs[g] > sq_abs);
    check_eq("complete_val", bus.complete_val, acc);
    if (acc) begin
      check_eq("complete_seq", bus.complete_seq_num, p_abs[g] % D);
      check_eq("complete_data",
               {bus.complete_wdata, bus.complete_waddr, bus.complete_preg, bus.complete_wen},
               {p_wd[g], p_wa[g], p_pr[g], p_we[g]});
    end
    n = model_ncommit();
    check_eq("commit_val", bus.commit_val, (64'd1 << n) - 64'd1);
    for (int k = 0; k < n; k++) begin
      idx = (m_head + k) % D;
      check_eq("commit_seq", bus.commit_seq_num[k], idx);
      check_eq("commit_pc", bus.commit_pc[k], m_pc[idx]);
      check_eq("commit_data",
               {bus.commit_wdata[k], bus.commit_waddr[k], bus.commit_preg[k], bus.commit_wen[k]},
               {m_wd[idx], m_wa[idx], m_pr[idx], m_we[idx]});
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      m_rst_prev = 1'b1;
    end else begin
      m_rst_prev = 1'b0;
      for (int k = 0; k < n; k++) m_valid[(m_head + k) % D] = 1'b0;
      m_head += n;
      if (sq_val) begin
        for (int s = 0; s < D; s++) begin
          if (m_valid[s] && m_abs[s] > sq_abs) m_valid[s] = 1'b0;
        end
      end
      if (acc) begin
        idx          = p_abs[g] % D;
        m_valid[idx] = 1'b1;
        m_abs[idx]   = p_abs[g];
        m_pc[idx]    = p_pc[g];
        m_wd[idx]    = p_wd[g];
        m_wa[idx]    = p_wa[g];
        m_pr[idx]    = p_pr[g];
        m_we[idx]    = p_we[g];
      end
      if (g >= 0) begin
        p_val[g] = 1'b0;
        m_ptr    = (g + 1) % N;
      end
      if (sq_val) begin
        for (int p = 0; p < N; p++) begin
          if (p_val[p] && p_abs[p] > sq_abs) p_val[p] = 1'b0;
        end
        tail   = sq_abs + 1;
        sq_val = 1'b0;
      end
    end
    #1;
  endtask

  // Legal random traffic: in-order allocation inside a D-deep window, and
  // squash points never older than the last entry committing this cycle.
  task automatic rand_stim();
    int n;
    int lo;
    for (int p = 0; p < N; p++) begin
      if (!p_val[p] && (tail - m_head) < D && $urandom_range(1, 0) == 1) begin
        issue(p, tail);
        tail++;
      end
    end
    n  = model_ncommit();
    lo = m_head + ((n > 0) ? n - 1 : 0);
    if ($urandom_range(15, 0) == 0 && lo < tail) begin
      sq_val = 1'b1;
      sq_abs = int'($urandom_range(tail - 1, lo));
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    m_rst_prev = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Pipes 0 and 2 always valid: grants alternate, commits in order.
    for (int c = 0; c < 14; c++) begin
      if (!p_val[0]) begin issue(0, tail); tail++; end
      if (!p_val[2]) begin issue(2, tail); tail++; end
      cycle();
    end
    for (int c = 0; c < 10; c++) cycle();

    // Out-of-order completion 2,1,0 from a fresh head of 0.
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    issue(0, 2); cycle();
    issue(0, 1); cycle();
    issue(0, 0); cycle();
    cycle(); cycle(); cycle();
    tail = 3;

    // Long random run (head wraps many times) with a mid-run reset.
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) rst = 1'b1;
      if (c == 2002) rst = 1'b0;
      if (!rst) rand_stim();
      cycle();
    end

    // Six entries pending behind a missing seq 0, then reset drops them.
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    issue(0, 1); issue(1, 2); issue(2, 3); issue(3, 4);
    for (int c = 0; c < 4; c++) cycle();
    issue(0, 5); issue(1, 6);
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    cycle();
    issue(0, 0); tail = 1;
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
